ahb_wrr_burst_arbiter: RTL and testbench

- Per-slave AHB arbiter: shares one slave port between MASTER_NUM masters using credit-weighted round-robin.
- Tracks burst beats on the muxed address bus, so ownership changes only at burst boundaries.
- Sits between the master request lines and the slave-side address/data mux; hgrant and hmaster drive that mux.
- Sibling of the per-slave arbiters in the arbiter directory; shares the same burst encoding.

---
 rtl/ahb_wrr_burst_arbiter_pkg.sv | 36 +++
 rtl/ahb_wrr_burst_arbiter_wrr_pick.sv | 33 +++
 rtl/ahb_wrr_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_ahb_wrr_burst_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ahb_wrr_burst_arbiter_pkg.sv
// Shared AHB arbiter definitions: burst encoding, HTRANS codes and burst length lookup.
package AHB_package;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } burst_type;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } arb_state_t;

    // Open-ended INCR reports 0; callers treat it separately.
    function automatic logic [4:0] burst_len(input burst_type b);
        case (b)
            SINGLE:         burst_len = 5'd1;
            WRAP4, INCR4:   burst_len = 5'd4;
            WRAP8, INCR8:   burst_len = 5'd8;
            WRAP16, INCR16: burst_len = 5'd16;
            default:        burst_len = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_wrr_burst_arbiter_wrr_pick.sv
// Rotating-priority picker: first eligible index at or after the round-robin pointer.
module wrr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     winner,
    output logic [IDX_W-1:0] winner_idx
);

    logic [IDX_W:0] cand;
    logic           found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!found && eligible[cand[IDX_W-1:0]]) begin
                found                      = 1'b1;
                winner[cand[IDX_W-1:0]]    = 1'b1;
                winner_idx                 = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_wrr_burst_arbiter.sv
// Per-slave AHB arbiter: credit-weighted round-robin, ownership changes only at burst boundaries.
module ahb_wrr_burst_arbiter
    import AHB_package::*;
#(
    parameter int MASTER_NUM   = 3,
    parameter int WEIGHT_W     = 4,
    parameter int MASTER_IDX_W = $clog2(MASTER_NUM)
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic [MASTER_NUM-1:0]          hreq,
    input  logic [MASTER_NUM*WEIGHT_W-1:0] weight,
    input  logic [1:0]                     htrans,
    input  burst_type                      hburst,
    input  logic                           hready,
    output logic [MASTER_NUM-1:0]          hgrant,
    output logic [MASTER_IDX_W-1:0]        hmaster,
    output logic                           hlast,
    output logic                           busy
);

    arb_state_t                state_q, state_d;
    logic [MASTER_NUM-1:0]     grant_q, grant_d;
    logic [MASTER_IDX_W-1:0]   master_q, master_d;
    logic [MASTER_IDX_W-1:0]   rr_q, rr_d;
    logic [4:0]                cnt_q, cnt_d;
    logic [4:0]                len_q, len_d;
    logic                      incr_q, incr_d;
    logic [WEIGHT_W-1:0]       credit_q [MASTER_NUM];
    logic [WEIGHT_W-1:0]       credit_d [MASTER_NUM];
    logic [WEIGHT_W-1:0]       base_credit [MASTER_NUM];

    logic [MASTER_NUM-1:0]     credit_nz, eligible, pick_vec, win_onehot;
    logic [MASTER_IDX_W-1:0]   win_idx;
    logic                      need_reload;
    logic                      accept, new_burst, cur_incr, incr_end, unused, arb_go;
    logic [4:0]                cur_idx, cur_len;

    // When every requester is out of credit, selection runs on the reloaded weights this same cycle.
    always_comb begin
        for (int i = 0; i < MASTER_NUM; i++) begin
            credit_nz[i] = (credit_q[i] != '0);
        end
        eligible    = hreq & credit_nz;
        need_reload = (hreq != '0) && (eligible == '0);
        pick_vec    = need_reload ? hreq : eligible;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (need_reload) begin
                base_credit[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                                          : weight[i*WEIGHT_W +: WEIGHT_W];
            end else begin
                base_credit[i] = credit_q[i];
            end
        end
    end

    wrr_pick #(
        .N     (MASTER_NUM),
        .IDX_W (MASTER_IDX_W)
    ) u_pick (
        .eligible   (pick_vec),
        .rr_ptr     (rr_q),
        .winner     (win_onehot),
        .winner_idx (win_idx)
    );

    always_comb begin
        accept    = (state_q == ST_OWN) && hready && htrans[1];
        new_burst = accept && (htrans == HTRANS_NONSEQ);
        cur_len   = new_burst ? burst_len(hburst) : len_q;
        cur_incr  = new_burst ? (hburst == INCR) : incr_q;
        cur_idx   = new_burst ? 5'd0 : cnt_q;
        hlast     = accept && !cur_incr && (cur_idx == cur_len - 5'd1);
        incr_end  = (state_q == ST_OWN) && hready && (htrans == HTRANS_IDLE) && incr_q && (cnt_q != 5'd0);
        unused    = (state_q == ST_OWN) && hready && (htrans == HTRANS_IDLE) && (cnt_q == 5'd0)
                    && !hreq[master_q];
        arb_go    = hready && ((state_q == ST_IDLE) ? (hreq != '0) : (hlast || incr_end || unused));
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        master_d = master_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        incr_d   = incr_q;
        for (int i = 0; i < MASTER_NUM; i++) begin
            credit_d[i] = credit_q[i];
        end
        if (arb_go) begin
            cnt_d  = '0;
            len_d  = '0;
            incr_d = 1'b0;
            if (hreq != '0) begin
                state_d  = ST_OWN;
                grant_d  = win_onehot;
                master_d = win_idx;
                rr_d     = (win_idx == MASTER_IDX_W'(MASTER_NUM-1)) ? '0 : win_idx + MASTER_IDX_W'(1);
                for (int i = 0; i < MASTER_NUM; i++) begin
                    credit_d[i] = win_onehot[i] ? base_credit[i] - WEIGHT_W'(1) : base_credit[i];
                end
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end else if (accept) begin
            // A NONSEQ always opens a fresh burst for the current owner.
            if (new_burst) begin
                cnt_d  = 5'd1;
                len_d  = burst_len(hburst);
                incr_d = (hburst == INCR);
            end else if (cnt_q != 5'd31) begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            master_q <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            incr_q   <= 1'b0;
            for (int i = 0; i < MASTER_NUM; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            incr_q   <= incr_d;
            for (int i = 0; i < MASTER_NUM; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign hgrant  = grant_q;
    assign hmaster = master_q;
    assign busy    = (state_q == ST_OWN);

endmodule

// File: tb/tb_ahb_wrr_burst_arbiter.sv
// Directed scoreboard bench for ahb_wrr_burst_arbiter with three masters.
module tb_ahb_wrr_burst_arbiter;
    import AHB_package::*;

    localparam int N  = 3;
    localparam int WW = 4;
    localparam int IW = 2;

    logic              hclk    = 1'b0;
    logic              hreset  = 1'b1;
    logic [N-1:0]      hreq    = '0;
    logic [N*WW-1:0]   weight  = '0;
    logic [1:0]        htrans  = HTRANS_IDLE;
    burst_type         hburst  = SINGLE;
    logic              hready  = 1'b1;
    logic [N-1:0]      hgrant;
    logic [IW-1:0]     hmaster;
    logic              hlast;
    logic              busy;

    typedef struct {
        logic [N-1:0]  grant;
        logic          busy;
        logic          hlast;
        logic [IW-1:0] master;
    } expT;

    expT   expQ[$];
    expT   monE;
    int    checks = 0;
    int    errors = 0;
    string curTest = "init";
    logic [N-1:0] seqC [8];

    ahb_wrr_burst_arbiter #(
        .MASTER_NUM   (N),
        .WEIGHT_W     (WW),
        .MASTER_IDX_W (IW)
    ) dut (
        .hclk    (hclk),
        .hreset  (hreset),
        .hreq    (hreq),
        .weight  (weight),
        .htrans  (htrans),
        .hburst  (hburst),
        .hready  (hready),
        .hgrant  (hgrant),
        .hmaster (hmaster),
        .hlast   (hlast),
        .busy    (busy)
    );

    always #5 hclk = ~hclk;

    // Drives one cycle of inputs and queues what the outputs must show during that cycle.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic [1:0] trans,
                                 input burst_type burst, input logic rdy,
                                 input logic [N-1:0] expGrant, input logic expHlast);
        expT e;
        @(posedge hclk);
        #1;
        hreset = rst;
        hreq   = req;
        htrans = trans;
        hburst = burst;
        hready = rdy;
        e.grant  = expGrant;
        e.busy   = |expGrant;
        e.hlast  = expHlast;
        e.master = '0;
        for (int i = 0; i < N; i++) begin
            if (expGrant[i]) e.master = IW'(i);
        end
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string what, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h, expected %0h at %0t", curTest, what, act, expv, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge hclk);
            if (expQ.size() > 0) begin
                monE = expQ.pop_front();
                checkOutput("hgrant", 8'(hgrant), 8'(monE.grant));
                checkOutput("busy", 8'(busy), 8'(monE.busy));
                checkOutput("hlast", 8'(hlast), 8'(monE.hlast));
                if (monE.busy) checkOutput("hmaster", 8'(hmaster), 8'(monE.master));
            end
        end
    end

    task automatic doReset();
        applyStimulus(1'b1, '0, HTRANS_IDLE, SINGLE, 1'b1, 3'b000, 1'b0);
    endtask

    initial begin
        weight = {4'd1, 4'd1, 4'd1};
        repeat (2) @(posedge hclk);

        curTest = "reset_mid_burst";
        applyStimulus(1'b0, 3'b001, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b001, HTRANS_NONSEQ, INCR8,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b001, HTRANS_SEQ,    INCR8,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b001, HTRANS_SEQ,    INCR8,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b1, 3'b001, HTRANS_SEQ,    INCR8,  1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b001, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);

        curTest = "rr_111";
        doReset();
        applyStimulus(1'b0, 3'b111, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b111, HTRANS_NONSEQ, SINGLE, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 3'b111, HTRANS_NONSEQ, SINGLE, 1'b1, 3'b010, 1'b1);
        applyStimulus(1'b0, 3'b111, HTRANS_NONSEQ, SINGLE, 1'b1, 3'b100, 1'b1);
        applyStimulus(1'b0, 3'b000, HTRANS_NONSEQ, SINGLE, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);

        // Master 2 has weight 0, which reloads as 1.
        curTest = "wrr_210";
        weight = {4'd0, 4'd1, 4'd2};
        seqC = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001};
        doReset();
        applyStimulus(1'b0, 3'b111, HTRANS_IDLE, SINGLE, 1'b1, 3'b000, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, (k == 7) ? 3'b000 : 3'b111, HTRANS_NONSEQ, SINGLE, 1'b1, seqC[k], 1'b1);
        end
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE, SINGLE, 1'b1, 3'b000, 1'b0);

        curTest = "incr4_wait";
        weight = {4'd1, 4'd1, 4'd1};
        doReset();
        applyStimulus(1'b0, 3'b001, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_NONSEQ, INCR4,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_SEQ,    INCR4,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_SEQ,    INCR4,  1'b0, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_SEQ,    INCR4,  1'b0, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_SEQ,    INCR4,  1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_SEQ,    INCR4,  1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b010, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);

        curTest = "incr_idle_end";
        doReset();
        applyStimulus(1'b0, 3'b100, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b100, HTRANS_NONSEQ, INCR,   1'b1, 3'b100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 3'b100, HTRANS_SEQ, INCR, 1'b1, 3'b100, 1'b0);
        end
        applyStimulus(1'b0, 3'b001, HTRANS_IDLE,   INCR,   1'b1, 3'b100, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b001, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);

        // The released master keeps its spent credit, so master 2 wins over it afterwards.
        curTest = "unused_grant";
        doReset();
        applyStimulus(1'b0, 3'b010, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b010, 1'b0);
        applyStimulus(1'b0, 3'b011, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b0, 3'b111, HTRANS_NONSEQ, SINGLE, 1'b1, 3'b001, 1'b1);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b100, 1'b0);
        applyStimulus(1'b0, 3'b000, HTRANS_IDLE,   SINGLE, 1'b1, 3'b000, 1'b0);

        repeat (2) @(posedge hclk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
